// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM receive path.
// Holds the channel count, the slot index width, the index of the last
// slot in a frame, and the lock state machine encoding.
package tdm_pkg;

  localparam int N_CH   = 8;
  localparam int SLOT_W = 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder used to steer a slot beat into its staging
// register. This is the receive-side counterpart of the 8:1 select path.
// Ports:
//   sel    - slot index to decode
//   en     - when low, no output bit is set
//   onehot - one-hot write enables, bit k for slot k
module dec3to8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] sel,
  input  logic              en,
  output logic [N_CH-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux8.sv
// Receive-end 8-channel time-division demultiplexer.
// Steers each valid slot beat into a staging register, publishes all eight
// channels at once when slot 7 arrives, and tracks frame lock via the
// frame_sync marker, pulsing sync_err on early or missing sync.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   din         - slot data, W bits
//   din_valid   - din carries a slot this cycle (low = gap)
//   frame_sync  - current valid beat is slot 0
//   dout        - published frame, channel k at [k*W +: W]
//   frame_valid - one-cycle pulse when dout updates
//   locked      - high while the FSM is in RUN
//   sync_err    - one-cycle pulse on a framing error
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] dout,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  state_e              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [W-1:0]        stg_q [N_CH];
  logic [N_CH*W-1:0]   dout_q;
  logic                frame_valid_q;
  logic                locked_q;
  logic                sync_err_q;

  logic [SLOT_W-1:0]   wr_slot;
  logic                wr_en;
  logic [N_CH-1:0]     wr_vec;
  logic [N_CH*W-1:0]   frame_d;

  // A sync beat always lands in slot 0. Beats are stored unless they are
  // dropped: non-sync beats in IDLE, or a missing sync at slot 0 in RUN.
  assign wr_slot = frame_sync ? '0 : slot_q;
  assign wr_en   = din_valid &&
                   (frame_sync || (state_q == RUN && slot_q != '0));

  dec3to8 u_dec (
    .sel    (wr_slot),
    .en     (wr_en),
    .onehot (wr_vec)
  );

  // Slot 7 is taken straight from din so the frame publishes on the same
  // edge that samples its last beat.
  always_comb begin
    frame_d = '0;
    for (int k = 0; k < N_CH - 1; k++) frame_d[k*W +: W] = stg_q[k];
    frame_d[(N_CH-1)*W +: W] = din;
  end

  // Staging array carries no reset: only completed frames reach dout.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (wr_vec[k]) stg_q[k] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (din_valid) begin
        case (state_q)
          IDLE: begin
            if (frame_sync) begin
              state_q  <= RUN;
              locked_q <= 1'b1;
              slot_q   <= SLOT_W'(1);
            end
          end
          RUN: begin
            if (frame_sync && slot_q != '0) begin
              // Early sync: abandon the partial frame, restart at slot 1.
              sync_err_q <= 1'b1;
              slot_q     <= SLOT_W'(1);
            end else if (!frame_sync && slot_q == '0) begin
              // Missing sync after a completed frame: drop beat, lose lock.
              sync_err_q <= 1'b1;
              state_q    <= IDLE;
              locked_q   <= 1'b0;
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
              if (slot_q == LAST_SLOT) begin
                dout_q        <= frame_d;
                frame_valid_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            slot_q   <= '0;
          end
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule
